pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter CORDW, default 10, coordinate width in bits (signed).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset_i  input  1  reset: one clock; reset is synchronous and active-high.
REQ-004 drawing_i  input  1  upstream has a valid pixel this cycle.
REQ-005 x_i, y_i  input  CORDW each, signed  pixel coordinate.
REQ-006 oe_o  output  1  ready; upstream advances only on cycles with oe_o=1.
REQ-007 base_i  input  16  VRAM word address of pixel (0,0).
REQ-008 line_words_i  input  16  VRAM words per line.
REQ-009 width_i, height_i  input  CORDW each, unsigned  clip limits in pixels.
REQ-010 color_i  input  4  4bpp color index.
REQ-011 vram_wr_o  output  1  write request, held until acknowledged.
REQ-012 vram_addr_o  output  16  write word address.
REQ-013 vram_mask_o  output  4  nibble write mask; bit 3 = high nibble.
REQ-014 vram_data_o  output  16  write data.
REQ-015 vram_ack_i  input  1  write accepted this cycle.
REQ-016 busy_o  output  1  a pixel is held internally.

Function
REQ-017 States IDLE, CALC, WRITE; oe_o = (state == IDLE), combinational.
REQ-018 Accept: IDLE with drawing_i=1 latches x_i, y_i, color_i, base_i, line_words_i, width_i, height_i; later input changes do not affect that pixel.
REQ-019 Clip: pixel with x<0, y<0, x>=width, or y>=height is accepted and discarded; state stays IDLE, no write, no stall.
REQ-020 Unclipped accepted pixel: IDLE -> CALC; busy_o=1 from the next cycle.
REQ-021 CALC: register addr = base + y*line_words + (x>>2), mod 2^16; mask = 4'b1000 >> x[1:0]; data = {4{color}}; -> WRITE.
REQ-022 WRITE: vram_wr_o=1 with addr/mask/data stable; on vram_ack_i=1 -> IDLE; vram_wr_o=0 and busy_o=0 from the next cycle.
REQ-023 Latency: accept at cycle N -> vram_wr_o first high at N+2; ack at N+2 -> oe_o=1 at N+3; minimum 3 cycles per written pixel.
REQ-024 vram_ack_i outside WRITE is ignored.
REQ-025 vram_wr_o=0 in IDLE and CALC; vram_addr_o, vram_mask_o, vram_data_o are don't-care when vram_wr_o=0.
REQ-026 Product y*line_words: unsigned 16-bit, truncated; no overflow flag.

Reset
REQ-027 reset_i takes priority over all other inputs in the same cycle.
REQ-028 Reset values: state IDLE, oe_o=1, vram_wr_o=0, busy_o=0, vram_addr_o=0, vram_mask_o=0, vram_data_o=0.
REQ-029 Reset during CALC or WRITE drops the pending pixel; no write is issued.

Structure
REQ-030 The state enum and VRAM width constants (16-bit address, 16-bit data, 4 nibbles per word) are defined in xosera_pkg.
REQ-031 Single module with no sub-module; one multiplier, registered once in CALC.

Verification
REQ-032 Unclipped pixel: base=0x1000, line_words=80, x=5, y=2, color=0xA, ack on first request cycle -> addr=0x10A1, mask=4'b0100, data=0xAAAA, wr high for exactly 1 cycle at N+2.
REQ-033 Clipped pixels: x=-1, y=0 and x=320 with width=320 -> no vram_wr_o; oe_o stays 1 throughout.
REQ-034 Ack stall: ack delayed 5 cycles -> wr, addr, mask, and data stable for 6 cycles; oe_o=0 and busy_o=1 for the whole stall; inputs changed mid-stall do not alter outputs.
REQ-035 Reset in WRITE: assert reset_i while wr=1 -> next cycle wr=0, oe_o=1, busy_o=0; a later ack causes no effect.
REQ-036 Address wrap: base=0xFFF0, line_words=16, y=1, x=4 -> addr=0x0001, mask=4'b1000.
REQ-037 Back-to-back: drive a 4-pixel horizontal run x=0..3, y=0, with acks immediate -> 4 writes at the same address, masks 1000, 0100, 0010, 0001, 3 cycles apart.

Source files
------------

// File: rtl/xosera_pkg.sv
// xosera_pkg
// Shared definitions for the pixel writer slice of the video core.
// Holds the pixel writer state type and the VRAM word geometry:
//   VRAM_ADDR_W      : width of a VRAM word address
//   VRAM_DATA_W      : width of a VRAM data word
//   NIBBLES_PER_WORD : number of 4bpp pixels packed into one word
//   MASK_FIRST       : write mask selecting the leftmost pixel (high nibble)
package xosera_pkg;

  localparam int VRAM_ADDR_W      = 16;
  localparam int VRAM_DATA_W      = 16;
  localparam int NIBBLES_PER_WORD = 4;

  localparam logic [NIBBLES_PER_WORD-1:0] MASK_FIRST = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } pw_state_t;

endpackage

// File: rtl/pixel_writer.sv
// pixel_writer
// Takes one 4bpp pixel at a time from an upstream drawing engine, drops it
// if it falls outside the clip window, otherwise converts its coordinate to
// a VRAM word address plus nibble mask and issues a single masked write,
// holding the request until the VRAM arbiter acknowledges it.
//
// Ports:
//   clk           : clock, everything on the rising edge
//   reset_i       : synchronous active-high reset
//   drawing_i     : upstream presents a valid pixel this cycle
//   x_i, y_i      : signed pixel coordinate
//   oe_o          : ready; upstream advances only when this is high
//   base_i        : VRAM word address of pixel (0,0)
//   line_words_i  : VRAM words per line
//   width_i       : clip width in pixels (unsigned)
//   height_i      : clip height in pixels (unsigned)
//   color_i       : 4bpp color index
//   vram_wr_o     : write request, held until acknowledged
//   vram_addr_o   : write word address
//   vram_mask_o   : nibble write mask, bit 3 is the high nibble
//   vram_data_o   : write data (color replicated into every nibble)
//   vram_ack_i    : VRAM accepted the write this cycle
//   busy_o        : a pixel is held internally
module pixel_writer
  import xosera_pkg::*;
#(
  parameter int CORDW = 10
) (
  input  logic                        clk,
  input  logic                        reset_i,
  input  logic                        drawing_i,
  input  logic signed [CORDW-1:0]     x_i,
  input  logic signed [CORDW-1:0]     y_i,
  output logic                        oe_o,
  input  logic [VRAM_ADDR_W-1:0]      base_i,
  input  logic [VRAM_ADDR_W-1:0]      line_words_i,
  input  logic [CORDW-1:0]            width_i,
  input  logic [CORDW-1:0]            height_i,
  input  logic [3:0]                  color_i,
  output logic                        vram_wr_o,
  output logic [VRAM_ADDR_W-1:0]      vram_addr_o,
  output logic [NIBBLES_PER_WORD-1:0] vram_mask_o,
  output logic [VRAM_DATA_W-1:0]      vram_data_o,
  input  logic                        vram_ack_i,
  output logic                        busy_o
);

  pw_state_t state_q, state_d;

  logic signed [CORDW-1:0]     x_q, y_q;
  logic [3:0]                  color_q;
  logic [VRAM_ADDR_W-1:0]      base_q, line_words_q;

  logic [VRAM_ADDR_W-1:0]      addr_q;
  logic [NIBBLES_PER_WORD-1:0] mask_q;
  logic [VRAM_DATA_W-1:0]      data_q;

  logic accept;
  logic clipped;

  logic [VRAM_ADDR_W-1:0] y_ext;
  logic [VRAM_ADDR_W-1:0] x_word;
  logic [VRAM_ADDR_W-1:0] row_offset;

  // The clip window is only consulted on the accept cycle, so width/height
  // are used straight from the inputs instead of being held.  Negative
  // coordinates are caught by the sign bit; the unsigned compares are only
  // meaningful once the sign bit is known to be clear.
  assign accept  = (state_q == IDLE) && drawing_i;
  assign clipped = x_i[CORDW-1] || y_i[CORDW-1] ||
                   ($unsigned(x_i) >= width_i) ||
                   ($unsigned(y_i) >= height_i);

  // Only unclipped coordinates ever reach CALC, so the held coordinates are
  // non-negative and can be zero-extended.  The product is deliberately
  // truncated to the address width so large frames wrap around VRAM.
  assign y_ext      = VRAM_ADDR_W'($unsigned(y_q));
  assign x_word     = VRAM_ADDR_W'($unsigned(x_q) >> 2);
  assign row_offset = y_ext * line_words_q;

  assign oe_o        = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign vram_wr_o   = (state_q == WRITE);
  assign vram_addr_o = addr_q;
  assign vram_mask_o = mask_q;
  assign vram_data_o = data_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clipped pixels are swallowed without leaving IDLE,
  // and an ack only matters while the request is actually on the bus.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (drawing_i && !clipped) state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   if (vram_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel capture: every accepted pixel is snapshotted so upstream is free
  // to move on immediately; later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      base_q       <= '0;
      line_words_q <= '0;
    end else if (accept) begin
      x_q          <= x_i;
      y_q          <= y_i;
      color_q      <= color_i;
      base_q       <= base_i;
      line_words_q <= line_words_i;
    end
  end

  // Write-request registers: the address is computed once in CALC so the
  // multiplier sits behind a register, and the bus values then stay frozen
  // for however long the VRAM takes to acknowledge.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      addr_q <= '0;
      mask_q <= '0;
      data_q <= '0;
    end else if (state_q == CALC) begin
      addr_q <= base_q + row_offset + x_word;
      mask_q <= MASK_FIRST >> x_q[1:0];
      data_q <= {NIBBLES_PER_WORD{color_q}};
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer
// Self-checking bench for pixel_writer.  A pixel-level model predicts,
// from the coordinate/clip/address rules, whether a pixel is pending and
// when its write must be visible, and every cycle the DUT outputs are
// compared against it.  Directed scenarios add literal expectations.
module tb_pixel_writer;
  import xosera_pkg::*;

  localparam int CORDW = 10;

  logic                    clk = 1'b0;
  logic                    reset_i = 1'b1;
  logic                    drawing_i = 1'b0;
  logic signed [CORDW-1:0] x_i = '0;
  logic signed [CORDW-1:0] y_i = '0;
  logic                    oe_o;
  logic [15:0]             base_i = '0;
  logic [15:0]             line_words_i = '0;
  logic [CORDW-1:0]        width_i = 10'd320;
  logic [CORDW-1:0]        height_i = 10'd240;
  logic [3:0]              color_i = '0;
  logic                    vram_wr_o;
  logic [15:0]             vram_addr_o;
  logic [3:0]              vram_mask_o;
  logic [15:0]             vram_data_o;
  logic                    vram_ack_i = 1'b0;
  logic                    busy_o;

  pixel_writer #(.CORDW(CORDW)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .drawing_i    (drawing_i),
    .x_i          (x_i),
    .y_i          (y_i),
    .oe_o         (oe_o),
    .base_i       (base_i),
    .line_words_i (line_words_i),
    .width_i      (width_i),
    .height_i     (height_i),
    .color_i      (color_i),
    .vram_wr_o    (vram_wr_o),
    .vram_addr_o  (vram_addr_o),
    .vram_mask_o  (vram_mask_o),
    .vram_data_o  (vram_data_o),
    .vram_ack_i   (vram_ack_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pixel-level model: one pixel may be outstanding; its write is due two
  // cycles after acceptance and retires on the first ack while due.
  int          cyc = 0;
  bit          have_pix = 1'b0;
  int          acc_cyc = 0;
  int          xv, yv;
  logic [15:0] m_addr = '0;
  logic [3:0]  m_mask = '0;
  logic [15:0] m_data = '0;
  bit          check_en = 1'b0;

  always @(posedge clk) begin
    if (reset_i) begin
      have_pix = 1'b0;
    end else if (have_pix) begin
      if ((cyc - acc_cyc) >= 2 && vram_ack_i) have_pix = 1'b0;
    end else if (drawing_i) begin
      xv = int'(x_i);
      yv = int'(y_i);
      if (xv >= 0 && yv >= 0 && xv < int'(width_i) && yv < int'(height_i)) begin
        have_pix = 1'b1;
        acc_cyc  = cyc;
        m_addr   = 16'((int'(base_i) + yv * int'(line_words_i) + xv / 4) % 65536);
        m_mask   = 4'(8 >> (xv % 4));
        m_data   = 16'(int'(color_i) * 32'h1111);
      end
    end
    cyc++;
  end

  // Reactive VRAM acknowledger: acks after ack_delay cycles of request.
  bit ack_en = 1'b1;
  bit ack_force = 1'b0;
  int ack_delay = 0;
  int wcnt = 0;

  always @(posedge clk) begin
    #2;
    if (!vram_wr_o) wcnt = 0;
    vram_ack_i = ack_force || (ack_en && vram_wr_o && wcnt == ack_delay);
    if (vram_wr_o) wcnt++;
  end

  // Write log observed at the bus, used by the directed checks.
  typedef struct {
    logic [15:0] addr;
    logic [3:0]  mask;
    logic [15:0] data;
    int          start;
    int          len;
  } wr_rec_t;

  wr_rec_t log_q[$];
  int run_len = 0;
  int run_start = 0;
  bit exp_wr;

  always @(negedge clk) begin
    if (check_en) begin
      exp_wr = have_pix && (cyc - acc_cyc) >= 2;
      checkOutput("oe", {31'd0, oe_o}, {31'd0, !have_pix});
      checkOutput("busy", {31'd0, busy_o}, {31'd0, have_pix});
      checkOutput("wr", {31'd0, vram_wr_o}, {31'd0, exp_wr});
      if (exp_wr) begin
        checkOutput("addr", {16'd0, vram_addr_o}, {16'd0, m_addr});
        checkOutput("mask", {28'd0, vram_mask_o}, {28'd0, m_mask});
        checkOutput("data", {16'd0, vram_data_o}, {16'd0, m_data});
      end
      if (vram_wr_o === 1'b1) begin
        if (run_len == 0) run_start = cyc;
        run_len++;
        if (vram_ack_i) begin
          log_q.push_back('{vram_addr_o, vram_mask_o, vram_data_o, run_start, run_len});
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
    end
  end

  // Presents one pixel and holds it until the DUT takes it; returns the
  // cycle index in which it was accepted.
  task automatic applyStimulus(input int x, input int y, input logic [3:0] color,
                               input logic [15:0] base, input logic [15:0] lw,
                               output int acc_at);
    bit ok = 1'b0;
    int guard = 0;
    logic [31:0] xs, ys;
    xs = x;
    ys = y;
    drawing_i    = 1'b1;
    x_i          = xs[CORDW-1:0];
    y_i          = ys[CORDW-1:0];
    color_i      = color;
    base_i       = base;
    line_words_i = lw;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = oe_o;
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("accept_in_time", {31'd0, ok}, 32'd1);
    acc_at    = cyc - 1;
    drawing_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int n0;
    int accs[4];
    int guard;

    repeat (1) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_oe", {31'd0, oe_o}, 32'd1);
    checkOutput("rst_wr", {31'd0, vram_wr_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_addr", {16'd0, vram_addr_o}, 32'd0);
    checkOutput("rst_mask", {28'd0, vram_mask_o}, 32'd0);
    checkOutput("rst_data", {16'd0, vram_data_o}, 32'd0);
    @(posedge clk);
    #1;

    // Single unclipped pixel, immediate ack
    n0 = log_q.size();
    applyStimulus(5, 2, 4'hA, 16'h1000, 16'd80, acc);
    checkOutput("model_addr_pin", {16'd0, m_addr}, 32'h10A1);
    checkOutput("model_mask_pin", {28'd0, m_mask}, 32'h4);
    idle_cycles(5);
    checkOutput("single_count", log_q.size(), n0 + 1);
    if (log_q.size() > n0) begin
      checkOutput("single_addr", {16'd0, log_q[n0].addr}, 32'h10A1);
      checkOutput("single_mask", {28'd0, log_q[n0].mask}, 32'h4);
      checkOutput("single_data", {16'd0, log_q[n0].data}, 32'hAAAA);
      checkOutput("single_start", log_q[n0].start, acc + 2);
      checkOutput("single_len", log_q[n0].len, 1);
    end

    // Clipped pixels: left of window and exactly at the width limit
    n0 = log_q.size();
    applyStimulus(-1, 0, 4'h3, 16'h0000, 16'd80, acc);
    applyStimulus(320, 0, 4'h3, 16'h0000, 16'd80, acc);
    idle_cycles(5);
    checkOutput("clip_count", log_q.size(), n0);

    // Ack stall of 5 cycles with inputs disturbed mid-stall
    ack_delay = 5;
    n0 = log_q.size();
    applyStimulus(7, 3, 4'h5, 16'h2000, 16'd40, acc);
    idle_cycles(3);
    x_i          = 10'sd100;
    y_i          = 10'sd50;
    color_i      = 4'hE;
    base_i       = 16'h7777;
    line_words_i = 16'd3;
    idle_cycles(10);
    ack_delay = 0;
    checkOutput("stall_count", log_q.size(), n0 + 1);
    if (log_q.size() > n0) begin
      checkOutput("stall_addr", {16'd0, log_q[n0].addr}, 32'h2079);
      checkOutput("stall_mask", {28'd0, log_q[n0].mask}, 32'h1);
      checkOutput("stall_data", {16'd0, log_q[n0].data}, 32'h5555);
      checkOutput("stall_len", log_q[n0].len, 6);
    end

    // Reset while the write request is up; a later ack must do nothing
    ack_en = 1'b0;
    n0 = log_q.size();
    applyStimulus(1, 1, 4'h3, 16'h0000, 16'd10, acc);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (vram_wr_o !== 1'b1 && guard < 20);
    checkOutput("rst_write_reached", {31'd0, vram_wr_o}, 32'd1);
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    checkOutput("rstw_wr", {31'd0, vram_wr_o}, 32'd0);
    checkOutput("rstw_oe", {31'd0, oe_o}, 32'd1);
    checkOutput("rstw_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
    ack_force = 1'b1;
    @(posedge clk);
    #1;
    ack_force = 1'b0;
    ack_en = 1'b1;
    idle_cycles(4);
    checkOutput("rstw_count", log_q.size(), n0);
    checkOutput("rstw_wr_after_ack", {31'd0, vram_wr_o}, 32'd0);

    // Address wrap past the top of VRAM
    n0 = log_q.size();
    applyStimulus(4, 1, 4'hF, 16'hFFF0, 16'd16, acc);
    checkOutput("model_wrap_pin", {16'd0, m_addr}, 32'h0001);
    idle_cycles(5);
    checkOutput("wrap_count", log_q.size(), n0 + 1);
    if (log_q.size() > n0) begin
      checkOutput("wrap_addr", {16'd0, log_q[n0].addr}, 32'h0001);
      checkOutput("wrap_mask", {28'd0, log_q[n0].mask}, 32'h8);
      checkOutput("wrap_data", {16'd0, log_q[n0].data}, 32'hFFFF);
    end

    // Back-to-back horizontal run within one word
    n0 = log_q.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, 0, 4'hC, 16'h0300, 16'd80, accs[i]);
    end
    idle_cycles(5);
    checkOutput("run_count", log_q.size(), n0 + 4);
    if (log_q.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("run_addr%0d", i), {16'd0, log_q[n0+i].addr}, 32'h0300);
        checkOutput($sformatf("run_mask%0d", i), {28'd0, log_q[n0+i].mask}, 32'(8 >> i));
        checkOutput($sformatf("run_data%0d", i), {16'd0, log_q[n0+i].data}, 32'hCCCC);
        if (i > 0)
          checkOutput($sformatf("run_gap%0d", i),
                      log_q[n0+i].start - log_q[n0+i-1].start, 3);
      end
    end

    idle_cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
